cache_line_wr_sched: RTL and testbench
======================================

# cache_line_wr_sched

Write-port scheduler for the 128-line array selected through the 7-to-128 line decoder. It shares the single line-write port between two refill requesters (port 0: I-side, port 1: D-side) with round-robin arbitration. It also runs a 128-cycle invalidate sweep on flush request. Outputs are a registered 7-bit line index, a matching registered one-hot write-enable vector, and the write qualifiers consumed by the cache tag/valid arrays.

## Interface
- `LINES`, 128: number of lines; fixed at 128 (7-bit index).
- `IDX_W`, 7: line index width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `flush_req`  in  1  level; sampled only in IDLE.
- `flush_busy`  out  1  high while sweep state is FLUSH.
- `flush_done`  out  1  one-cycle pulse with the final sweep write.
- `req0_valid`  in  1  port 0 write request.
- `req0_idx`  in  7  port 0 line index.
- `req0_ready`  out  1  port 0 granted this cycle (combinational).
- `req1_valid`, `req1_idx`, `req1_ready`: same as port 0, for port 1.
- `wr_en`  out  1  registered line write strobe.
- `wr_idx`  out  7  registered line index.
- `wr_onehot`  out  128  registered; `1 << wr_idx` when `wr_en`, else all zero.
- `wr_src`  out  2  registered source: 00 port0, 01 port1, 10 flush.
- `wr_clr`  out  1  registered; high only for flush writes (clear valid bit).

## Operation
- States: IDLE, FLUSH. Reset state is IDLE.
- Sweep counter `cnt[6:0]` resets to 0.
- Round-robin pointer `last` resets to 1, so port 0 wins the first contention.
- IDLE, `flush_req`=1:
  - Next state is FLUSH and `cnt` is set to 0.
  - No grant is issued that cycle; flush beats requests arriving in the same cycle.
- IDLE, `flush_req`=0, arbitration:
  - Only one port valid: grant that port.
  - Both ports valid: grant the port that is not `last`.
  - Neither valid: no grant.
- `reqN_ready` = grant to port N; it is never high in FLUSH.
- A transfer occurs when `valid & ready`. On transfer, `last` updates to the granted port.
- FLUSH:
  - Each cycle registers a write of `cnt` with `wr_src`=10 and `wr_clr`=1, then increments `cnt`.
  - When `cnt`=127, the next state is IDLE and `cnt` wraps to 0.
  - `flush_req` is ignored while in FLUSH. A level still high on return to IDLE starts a new sweep.
- Output registers for each grant or sweep step:
  - `wr_en`=1.
  - `wr_idx` = index.
  - `wr_onehot` = one-hot decode of that index.
  - `wr_src` and `wr_clr` set per source.
- Cycles with no grant and no sweep step: `wr_en`=0, `wr_onehot`=0, `wr_clr`=0. `wr_idx` and `wr_src` hold their last value.
- `flush_done` is registered high with the write of index 127 only.
- Exactly one bit of `wr_onehot` is set whenever `wr_en`=1.
- Reset values: `wr_en`, `wr_idx`, `wr_onehot`, `wr_src`, `wr_clr`, `flush_busy`, `flush_done` are all 0.
- Reset asserted mid-sweep:
  - All outputs clear immediately and the state returns to IDLE.
  - `flush_done` does not pulse, and the sweep does not resume after reset.

## Timing
- Grant latency: handshake in cycle N gives `wr_en` and the index on outputs in N+1. Back-to-back grants sustain one write per cycle.
- Flush sampled in IDLE at cycle N:
  - `flush_busy` is high in N+1 through N+128.
  - Sweep writes of index k appear at N+2+k (k = 0..127).
  - `flush_done` pulses at N+129, together with the index-127 write.
- The state is IDLE at N+129, so a grant can occur in N+129, with its write at N+130. There is no write collision with the sweep.
- A request held valid during a flush must stay valid with a stable index until ready. There is no drop or overtake.

## Test plan
- Reset with both requests valid → all outputs 0. After release, port 0 is granted first, then port 1 alternates; with both held valid the grant sequence is 0,1,0,1.
- `req0_valid`=1, `req0_idx`=0x05 at cycle N → `wr_en`=1, `wr_idx`=0x05, `wr_onehot` bit 5 only, `wr_src`=00, `wr_clr`=0 at N+1.
- `req1_idx`=0x7F single grant → `wr_onehot`=1<<127, `wr_src`=01. `req0_idx`=0x00 → `wr_onehot`=0x1.
- Flush pulse at N with `req0_valid` also high:
  - No grant in cycles N through N+128.
  - Indices 0..127 written in order at N+2..N+129, each with `wr_clr`=1.
  - `flush_done` pulses only at N+129.
  - `req0` is granted at N+129 and its write appears at N+130.
- Reset asserted at sweep index 60 → outputs 0 immediately. After release, state is IDLE, no `flush_done`, and a new flush restarts from index 0.
- `flush_req` held high for 300 cycles → two back-to-back sweeps, each with its own `flush_done`, separated by exactly one IDLE cycle with no write.

Source files
------------

// File: rtl/cache_line_wr_sched.sv
// Line-write port scheduler: round-robin between I-side and D-side refills,
// plus a full 128-line invalidate sweep on flush request.
module cache_line_wr_sched #(
    parameter int LINES = 128,
    parameter int IDX_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_req,
    output logic              flush_busy,
    output logic              flush_done,
    input  logic              req0_valid,
    input  logic [IDX_W-1:0]  req0_idx,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [IDX_W-1:0]  req1_idx,
    output logic              req1_ready,
    output logic              wr_en,
    output logic [IDX_W-1:0]  wr_idx,
    output logic [LINES-1:0]  wr_onehot,
    output logic [1:0]        wr_src,
    output logic              wr_clr
);

    typedef enum logic {IDLE, FLUSH} state_t;

    localparam logic [1:0]       SRC_P0   = 2'b00;
    localparam logic [1:0]       SRC_P1   = 2'b01;
    localparam logic [1:0]       SRC_FL   = 2'b10;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES - 1);

    state_t           state;
    logic [IDX_W-1:0] cnt;
    logic             last;
    logic             grant0;
    logic             grant1;

    function automatic logic [LINES-1:0] decode(input logic [IDX_W-1:0] idx);
        logic [LINES-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // A pending flush request blocks both ports for the cycle it is taken.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !flush_req) begin
            if (req0_valid && req1_valid) begin
                grant0 = last;
                grant1 = !last;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign flush_busy = (state == FLUSH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            last       <= 1'b1;
            wr_en      <= 1'b0;
            wr_idx     <= '0;
            wr_onehot  <= '0;
            wr_src     <= SRC_P0;
            wr_clr     <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            wr_onehot  <= '0;
            wr_clr     <= 1'b0;
            flush_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush_req) begin
                        state <= FLUSH;
                        cnt   <= '0;
                    end else if (grant0) begin
                        wr_en     <= 1'b1;
                        wr_idx    <= req0_idx;
                        wr_onehot <= decode(req0_idx);
                        wr_src    <= SRC_P0;
                        last      <= 1'b0;
                    end else if (grant1) begin
                        wr_en     <= 1'b1;
                        wr_idx    <= req1_idx;
                        wr_onehot <= decode(req1_idx);
                        wr_src    <= SRC_P1;
                        last      <= 1'b1;
                    end
                end
                FLUSH: begin
                    wr_en     <= 1'b1;
                    wr_idx    <= cnt;
                    wr_onehot <= decode(cnt);
                    wr_src    <= SRC_FL;
                    wr_clr    <= 1'b1;
                    if (cnt == LAST_IDX) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        flush_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_line_wr_sched.sv
// Bench for cache_line_wr_sched: cycle-indexed reference model plus directed
// scenarios with hand-computed expectations.
module tb_cache_line_wr_sched;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         flush_req = 1'b0;
    logic         flush_busy;
    logic         flush_done;
    logic         req0_valid = 1'b0;
    logic [6:0]   req0_idx = '0;
    logic         req0_ready;
    logic         req1_valid = 1'b0;
    logic [6:0]   req1_idx = '0;
    logic         req1_ready;
    logic         wr_en;
    logic [6:0]   wr_idx;
    logic [127:0] wr_onehot;
    logic [1:0]   wr_src;
    logic         wr_clr;

    int checks = 0;
    int errors = 0;

    cache_line_wr_sched #(.LINES(128), .IDX_W(7)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_req  (flush_req),
        .flush_busy (flush_busy),
        .flush_done (flush_done),
        .req0_valid (req0_valid),
        .req0_idx   (req0_idx),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_idx   (req1_idx),
        .req1_ready (req1_ready),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_onehot  (wr_onehot),
        .wr_src     (wr_src),
        .wr_clr     (wr_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: a flush sampled in cycle fs makes cycles fs+1..fs+128
    // busy, and the output in cycle fs+2+k is the sweep write of index k.
    int           m_cyc = 0;
    int           m_fs = -1;
    int           m_last = 1;
    logic         m_en = 1'b0;
    logic [6:0]   m_idx = '0;
    logic [127:0] m_oh = '0;
    logic [1:0]   m_src = '0;
    logic         m_clr = 1'b0;
    logic         m_done = 1'b0;

    function automatic bit in_flush(input int c, input int fs);
        return (fs >= 0) && (c - fs >= 1) && (c - fs <= 128);
    endfunction

    function automatic int mgrant(input bit v0, input bit v1, input int lastp,
                                  input bit idle, input bit fr);
        if (!idle || fr) return -1;
        if (v0 && v1) return (lastp == 1) ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc  <= 0;
            m_fs   <= -1;
            m_last <= 1;
            m_en   <= 1'b0;
            m_idx  <= '0;
            m_oh   <= '0;
            m_src  <= '0;
            m_clr  <= 1'b0;
            m_done <= 1'b0;
        end else begin
            int k;
            int g;
            m_en   <= 1'b0;
            m_oh   <= '0;
            m_clr  <= 1'b0;
            m_done <= 1'b0;
            if (in_flush(m_cyc, m_fs)) begin
                k = m_cyc - m_fs - 1;
                m_en   <= 1'b1;
                m_idx  <= k[6:0];
                m_oh   <= 128'd1 << k;
                m_src  <= 2'b10;
                m_clr  <= 1'b1;
                m_done <= (k == 127);
            end else if (flush_req) begin
                m_fs <= m_cyc;
            end else begin
                g = mgrant(req0_valid, req1_valid, m_last, 1'b1, 1'b0);
                if (g == 0) begin
                    m_en <= 1'b1; m_idx <= req0_idx; m_oh <= 128'd1 << req0_idx;
                    m_src <= 2'b00; m_last <= 0;
                end else if (g == 1) begin
                    m_en <= 1'b1; m_idx <= req1_idx; m_oh <= 128'd1 << req1_idx;
                    m_src <= 2'b01; m_last <= 1;
                end
            end
            m_cyc <= m_cyc + 1;
        end
    end

    always @(negedge clk) begin
        int g;
        chk("wr_en", wr_en, m_en);
        chk("wr_idx", wr_idx, m_idx);
        chk("wr_onehot", wr_onehot, m_oh);
        chk("wr_src", wr_src, m_src);
        chk("wr_clr", wr_clr, m_clr);
        chk("flush_done", flush_done, m_done);
        chk("flush_busy", flush_busy, in_flush(m_cyc, m_fs));
        if (rst_n) begin
            g = mgrant(req0_valid, req1_valid, m_last, !in_flush(m_cyc, m_fs), flush_req);
            chk("req0_ready", req0_ready, g == 0);
            chk("req1_ready", req1_ready, g == 1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int done_at;
        int done_cnt;

        // Reset with both ports requesting
        #1 rst_n = 1'b0;
        req0_valid = 1'b1; req0_idx = 7'h11;
        req1_valid = 1'b1; req1_idx = 7'h22;
        tick(3);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_onehot", wr_onehot, 128'h0);
        chk("rst_busy", flush_busy, 1'b0);
        rst_n = 1'b1;
        tick(1);
        chk("rr_first_src", wr_src, 2'b00);
        chk("rr_first_idx", wr_idx, 7'h11);
        tick(1);
        chk("rr_second_src", wr_src, 2'b01);
        chk("rr_second_idx", wr_idx, 7'h22);
        tick(1);
        chk("rr_third_src", wr_src, 2'b00);
        tick(1);
        chk("rr_fourth_src", wr_src, 2'b01);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick(2);

        // Single grants and decode boundaries
        req0_valid = 1'b1; req0_idx = 7'h05;
        tick(1);
        chk("p0_idx5_en", wr_en, 1'b1);
        chk("p0_idx5_idx", wr_idx, 7'h05);
        chk("p0_idx5_onehot", wr_onehot, 128'h20);
        chk("p0_idx5_src", wr_src, 2'b00);
        chk("p0_idx5_clr", wr_clr, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_idx = 7'h7F;
        tick(1);
        chk("p1_idx127_onehot", wr_onehot, 128'h8000_0000_0000_0000_0000_0000_0000_0000);
        chk("p1_idx127_src", wr_src, 2'b01);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_idx = 7'h00;
        tick(1);
        chk("p0_idx0_onehot", wr_onehot, 128'h1);
        req0_valid = 1'b0;
        tick(1);
        chk("idle_no_write", wr_en, 1'b0);
        chk("idle_idx_hold", wr_idx, 7'h00);

        // Flush pulse colliding with a port 0 request
        flush_req = 1'b1; req0_valid = 1'b1; req0_idx = 7'h33;
        tick(1);
        flush_req = 1'b0;
        done_at = -1;
        for (int i = 1; i <= 200; i++) begin
            if (flush_done) begin
                done_at = i;
                break;
            end
            tick(1);
        end
        chk("flush_done_cycle", done_at, 129);
        chk("flush_last_idx", wr_idx, 7'd127);
        chk("post_flush_ready", req0_ready, 1'b1);
        tick(1);
        chk("post_flush_wr_en", wr_en, 1'b1);
        chk("post_flush_src", wr_src, 2'b00);
        chk("post_flush_idx", wr_idx, 7'h33);
        req0_valid = 1'b0;
        tick(2);

        // Reset in the middle of a sweep
        flush_req = 1'b1;
        tick(1);
        flush_req = 1'b0;
        tick(61);
        chk("sweep_idx60", wr_idx, 7'd60);
        chk("sweep_idx60_clr", wr_clr, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_en", wr_en, 1'b0);
        chk("midrst_idx", wr_idx, 7'd0);
        chk("midrst_busy", flush_busy, 1'b0);
        chk("midrst_onehot", wr_onehot, 128'h0);
        tick(2);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 140; i++) begin
            tick(1);
            if (flush_done) done_cnt++;
        end
        chk("midrst_no_done", done_cnt, 0);
        chk("midrst_idle", flush_busy, 1'b0);
        flush_req = 1'b1;
        tick(1);
        flush_req = 1'b0;
        tick(1);
        chk("restart_idx0", wr_idx, 7'd0);
        chk("restart_clr", wr_clr, 1'b1);
        tick(135);

        // flush_req held high: back-to-back sweeps
        flush_req = 1'b1;
        done_cnt = 0;
        for (int i = 1; i <= 300; i++) begin
            tick(1);
            if (flush_done) done_cnt++;
            if (i == 129) chk("hold_done1", flush_done, 1'b1);
            if (i == 130) chk("hold_gap", wr_en, 1'b0);
            if (i == 131) chk("hold_second_idx0", wr_idx, 7'd0);
            if (i == 258) chk("hold_done2", flush_done, 1'b1);
        end
        flush_req = 1'b0;
        chk("hold_done_count", done_cnt, 2);
        tick(140);
        chk("final_idle", flush_busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
